// File: rtl/named_blk_scan_reader_if.sv
// Writer/scan bus for named_blk_scan_reader: write port toward the slots, beat stream out.
interface named_blk_scan_reader_if #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned WIDTH   = 8
);
    localparam int unsigned IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             busy;
    logic             out_valid;
    logic [IW-1:0]    out_idx;
    logic [WIDTH-1:0] out_data;
    logic             done;

    // Requester side: drives writes and scan start, observes the beat stream.
    modport master (
        output wr_en, wr_idx, wr_data, start,
        input  busy, out_valid, out_idx, out_data, done
    );

    // Reader block side.
    modport slave (
        input  wr_en, wr_idx, wr_data, start,
        output busy, out_valid, out_idx, out_data, done
    );
endinterface

// File: rtl/named_blk_scan_reader.sv
// Named-block slot storage with a scan FSM that streams slot[i].x out one slot per cycle.
// Optional feature macro: NAMED_BLK_SCAN_CHECKSUM_EN appends an XOR checksum beat (idx 0).
module named_blk_scan_reader #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    named_blk_scan_reader_if.slave       bus
);
    localparam int unsigned   IW   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_SLOTS - 1);

`ifdef NAMED_BLK_SCAN_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2, CSUM = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;
`endif

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [WIDTH-1:0] rd_vec [N_SLOTS];
`ifdef NAMED_BLK_SCAN_CHECKSUM_EN
    logic [WIDTH-1:0] acc;
`endif

    // Per-slot storage; an out-of-range index matches no slot, so the write is dropped.
    for (genvar i = 0; i < N_SLOTS; i++) begin : slot
        logic [WIDTH-1:0] x;

        // Slot register: reset value i+1, updated by a matching write in any FSM state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x <= WIDTH'(i + 1);
            end else if (bus.wr_en && (bus.wr_idx == IW'(i))) begin
                x <= bus.wr_data;
            end
        end
    end : slot

    // Hierarchical read-back of each named slot into a mux-able vector.
    for (genvar j = 0; j < N_SLOTS; j++) begin : rd
        assign rd_vec[j] = slot[j].x;
    end : rd

    // Scan FSM with registered outputs; FIN is the cycle that carries the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_data  <= '0;
            bus.done      <= 1'b0;
`ifdef NAMED_BLK_SCAN_CHECKSUM_EN
            acc           <= '0;
`endif
        end else begin
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    bus.busy      <= 1'b1;
                    bus.out_valid <= 1'b1;
                    bus.out_idx   <= ptr;
                    bus.out_data  <= rd_vec[ptr];
`ifdef NAMED_BLK_SCAN_CHECKSUM_EN
                    acc           <= acc ^ rd_vec[ptr];
`endif
                    if (ptr == LAST) begin
                        ptr <= '0;
`ifdef NAMED_BLK_SCAN_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= FIN;
`endif
                    end else begin
                        ptr <= ptr + IW'(1);
                    end
                end
`ifdef NAMED_BLK_SCAN_CHECKSUM_EN
                CSUM: begin
                    bus.busy      <= 1'b1;
                    bus.out_valid <= 1'b1;
                    bus.out_idx   <= '0;
                    bus.out_data  <= acc;
                    acc           <= '0;
                    state         <= FIN;
                end
`endif
                FIN: begin
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_named_blk_scan_reader.sv
// Bench for named_blk_scan_reader: directed literal scans plus random traffic vs. a slot/beat model.
module tb_named_blk_scan_reader;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 2;
`ifdef NAMED_BLK_SCAN_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int NB = N + int'(CSUM_EN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    named_blk_scan_reader_if #(.N_SLOTS(N), .WIDTH(W)) bus ();
    named_blk_scan_reader #(.N_SLOTS(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Six-slot instance: 3-bit index makes out-of-range writes (6, 7) expressible.
    named_blk_scan_reader_if #(.N_SLOTS(6), .WIDTH(W)) bus6 ();
    named_blk_scan_reader #(.N_SLOTS(6), .WIDTH(W)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: slot array plus "scan active, next beat number" bookkeeping.
    logic [W-1:0]  m_slot [N];
    bit            m_active;
    int            m_beat;
    logic [W-1:0]  m_acc;
    logic          m_busy, m_valid, m_done;
    logic [IW-1:0] m_idx;
    logic [W-1:0]  m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_slot[i] = W'(i + 1);
            m_active = 1'b0; m_beat = 0; m_acc = '0;
            m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_idx = '0; m_data = '0;
        end else begin
            m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            if (m_active) begin
                if (m_beat < N) begin
                    m_valid = 1'b1; m_busy = 1'b1;
                    m_idx = IW'(m_beat); m_data = m_slot[m_beat];
                    m_acc = m_acc ^ m_data;
                    m_beat++;
                end else if (CSUM_EN && m_beat == N) begin
                    m_valid = 1'b1; m_busy = 1'b1;
                    m_idx = '0; m_data = m_acc; m_acc = '0;
                    m_beat++;
                end else begin
                    m_done = 1'b1; m_active = 1'b0;
                end
            end else if (bus.start) begin
                m_active = 1'b1; m_beat = 0;
            end
            if (bus.wr_en && int'(bus.wr_idx) < int'(N)) m_slot[bus.wr_idx] = bus.wr_data;
        end
    end

    // Every-cycle compare of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy",      32'(bus.busy),      32'(m_busy));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_idx",   32'(bus.out_idx),   32'(m_idx));
        check("out_data",  32'(bus.out_data),  32'(m_data));
        check("done",      32'(bus.done),      32'(m_done));
    end

    // Beat capture for literal expectations.
    logic [IW-1:0] bidx [$];
    logic [W-1:0]  bdat [$];
    int            bcyc [$];
    int            dcyc [$];
    int            nbusy;
    logic [W-1:0]  b6dat [$];
    int            d6cnt;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            bidx.push_back(bus.out_idx); bdat.push_back(bus.out_data); bcyc.push_back(cyc);
        end
        if (bus.done) dcyc.push_back(cyc);
        if (bus.busy) nbusy++;
        if (bus6.out_valid) b6dat.push_back(bus6.out_data);
        if (bus6.done) d6cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_scan(output int s);
        bidx.delete(); bdat.delete(); bcyc.delete(); dcyc.delete(); nbusy = 0;
        bus.start = 1'b1;
        s = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic finish_scan(input string tag);
        for (int k = 0; k < 30 && dcyc.size() == 0; k++) tick();
        if (dcyc.size() == 0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    task automatic expect_scan(input string tag, input int s, input logic [W-1:0] e [5]);
        check({tag, "_nbeats"}, 32'(bdat.size()), 32'(NB));
        check({tag, "_ndone"},  32'(dcyc.size()), 32'd1);
        check({tag, "_nbusy"},  32'(nbusy),       32'(NB));
        if (bdat.size() == NB && dcyc.size() == 1) begin
            for (int k = 0; k < NB; k++) begin
                check($sformatf("%s_idx%0d", tag, k),  32'(bidx[k]), (k < N) ? 32'(k) : 32'd0);
                check($sformatf("%s_data%0d", tag, k), 32'(bdat[k]), 32'(e[k]));
                check($sformatf("%s_cyc%0d", tag, k),  32'(bcyc[k]), 32'(s + 2 + k));
            end
            check({tag, "_donecyc"}, 32'(dcyc[0]), 32'(s + 2 + NB));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [W-1:0] e [5];
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.start = 1'b0;
        bus6.wr_en = 1'b0; bus6.wr_idx = '0; bus6.wr_data = '0; bus6.start = 1'b0;
        nbusy = 0; d6cnt = 0;
        rst = 1'b1;
        repeat (2) tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        rst = 1'b0;
        tick();

        // Default contents.
        run_scan(s); finish_scan("dflt");
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        expect_scan("dflt", s, e);

        // Write while idle.
        do_reset();
        bus.wr_en = 1'b1; bus.wr_idx = 2'd2; bus.wr_data = 8'hA5; tick(); bus.wr_en = 1'b0;
        run_scan(s); finish_scan("wr");
        e = '{8'h01, 8'h02, 8'hA5, 8'h04, 8'hA2};
        expect_scan("wr", s, e);

        // Collision: write slot 3 in the cycle it is read.
        do_reset();
        run_scan(s);
        repeat (3) tick();
        bus.wr_en = 1'b1; bus.wr_idx = 2'd3; bus.wr_data = 8'h3C; tick(); bus.wr_en = 1'b0;
        finish_scan("coll1");
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        expect_scan("coll1", s, e);
        run_scan(s); finish_scan("coll2");
        e = '{8'h01, 8'h02, 8'h03, 8'h3C, 8'h3C};
        expect_scan("coll2", s, e);

        // start while busy is ignored; out-of-range writes on the six-slot instance are dropped.
        do_reset();
        b6dat.delete(); d6cnt = 0;
        bus6.wr_en = 1'b1; bus6.wr_idx = 3'd7; bus6.wr_data = 8'hFF; tick();
        bus6.wr_idx = 3'd6; tick();
        bus6.wr_en = 1'b0; bus6.start = 1'b1;
        run_scan(s);
        bus6.start = 1'b0;
        tick();
        bus.start = 1'b1; repeat (2) tick(); bus.start = 1'b0;
        finish_scan("busy");
        repeat (6) tick();
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        expect_scan("busy", s, e);
        check("oor_nbeats", 32'(b6dat.size()), 32'(6 + int'(CSUM_EN)));
        check("oor_ndone",  32'(d6cnt), 32'd1);
        for (int k = 0; k < 6 && k < b6dat.size(); k++)
            check($sformatf("oor_data%0d", k), 32'(b6dat[k]), 32'(k + 1));
        if (CSUM_EN && b6dat.size() == 7) check("oor_csum", 32'(b6dat[6]), 32'h07);

        // Reset during the idx 1 beat aborts with no done.
        run_scan(s);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_idx",   32'(bus.out_idx),   32'd0);
        check("abort_data",  32'(bus.out_data),  32'd0);
        check("abort_busy",  32'(bus.busy),      32'd0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("abort_nodone", 32'(dcyc.size()), 32'd0);
        run_scan(s); finish_scan("fresh");
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        expect_scan("fresh", s, e);

        // Random traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.start   = ($urandom_range(0, 7) == 0);
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_idx  = IW'($urandom_range(0, N - 1));
            bus.wr_data = W'($urandom);
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
